// File: rtl/timer_arbiter.sv
// timer_arbiter: N requesters share one up-counter. An idle block grants
// round-robin; the winner's preset is loaded and counted up to all-ones,
// then done pulses for one cycle and the block returns to idle. Dropping
// the request while running aborts the interval without a done pulse.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous, active-low reset
//   req     [N]        level request per requester, held until done/abort
//   preset  [N*WIDTH]  per-requester start value, slice i = [i*WIDTH +: WIDTH]
//   gnt     [N]        registered one-hot grant, zero when idle
//   done    [N]        one-cycle completion pulse to the granted requester
//   busy               high in RUN or DONE
//   count   [WIDTH]    shared counter value
module timer_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] preset,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic               busy,
  output logic [WIDTH-1:0]   count
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [N-1:0]     gnt_nx;
  logic [WIDTH-1:0] count_nx;
  logic [IW-1:0]    sel, sel_nx;
  logic [IW-1:0]    last, last_nx;
  logic [IW-1:0]    pick;
  logic             pick_vld;

  // Round-robin search: first requester after 'last', wrapping mod N.
  always_comb begin
    logic [IW-1:0] cand;
    pick     = last;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    count_nx = count;
    sel_nx   = sel;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = RUN;
          gnt_nx   = N'(1) << pick;
          count_nx = preset[pick*WIDTH +: WIDTH];
          sel_nx   = pick;
        end
      end
      RUN: begin
        if (!req[sel]) begin
          // abort: count is left frozen at its current value
          state_nx = IDLE;
          gnt_nx   = '0;
          last_nx  = sel;
        end else if (&count) begin
          state_nx = DONE;          // saturate, never wrap
        end else begin
          count_nx = count + WIDTH'(1);
        end
      end
      DONE: begin
        // always one idle edge after completion, even if requests wait
        state_nx = IDLE;
        gnt_nx   = '0;
        last_nx  = sel;
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      count <= '0;
      sel   <= '0;
      last  <= IW'(N - 1);          // req[0] wins first
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      count <= count_nx;
      sel   <= sel_nx;
      last  <= last_nx;
    end
  end

  assign done = (state == DONE) ? gnt : '0;
  assign busy = (state != IDLE);

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters sharing the counter (2..8).
REQ-002 Parameter WIDTH, default 16, counter and preset width in bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-low; clock clk.
REQ-005 req  input  N  per-requester level request for one timed interval; held high until done or abort.
REQ-006 preset  input  N*WIDTH  per-requester start value; slice i is bits [i*WIDTH +: WIDTH].
REQ-007 gnt  output  N  one-hot registered grant; zero when no interval is active.
REQ-008 done  output  N  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high while the state is RUN or DONE.
REQ-010 count  output  WIDTH  current shared counter value.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-012 IDLE with req nonzero: the block SHALL grant round-robin, starting at index (last+1) mod N, where last is the most recently served or aborted index.
REQ-013 On grant: at the same edge, state <= RUN, gnt <= one-hot(sel), count <= preset slice sel; sel SHALL be stored internally.
REQ-014 Preset changes after the grant edge SHALL have no effect on the active interval.
REQ-015 RUN with req[sel]=1 and count != all-ones: count SHALL increment by 1.
REQ-016 RUN with req[sel]=1 and count == all-ones: state <= DONE; count SHALL hold; there SHALL be no wrap to zero.
REQ-017 DONE: done SHALL equal gnt for exactly one cycle (done = gnt when state==DONE, else 0).
REQ-018 DONE: at the next edge, state <= IDLE, gnt <= 0, last <= sel; regardless of req, no new grant SHALL occur on that edge.
REQ-019 Abort: RUN with req[sel]=0 at an edge: state <= IDLE, gnt <= 0, last <= sel; done SHALL NOT pulse; count SHALL hold its value.
REQ-020 Latency: from the grant edge to the DONE state SHALL take (2^WIDTH - 1 - P) + 1 edges, where P is the preset value.
REQ-021 Preset = all-ones: the block SHALL enter DONE on the first edge after the grant.
REQ-022 Requests from non-granted requesters SHALL be ignored until the block returns to IDLE; no preemption.
REQ-023 Only one bit of gnt and done SHALL ever be high at a time.
REQ-024 count SHALL hold its value in IDLE.

Reset
REQ-025 rst=0 at a clock edge: state <= IDLE, gnt <= 0, count <= 0, last <= N-1, so req[0] has first priority.
REQ-026 Reset SHALL take precedence over all other behaviour, including mid-RUN and in DONE; done SHALL be 0 during and after a reset edge.
REQ-027 All outputs SHALL be registered, or derived only from registered state.

Verification (N=4, WIDTH=16)
REQ-028 Single request: req=0001, preset0=0xFFFD sampled at edge k.
  -> count FFFD, FFFE, FFFF after edges k, k+1, k+2.
  -> done=0001 during the cycle after edge k+3.
  -> gnt=0000 after edge k+4.
REQ-029 Round-robin: req=1111 held continuously, all presets 0xFFFF.
  -> grant order 0,1,2,3,0.
  -> each grant lasts 2 cycles plus 1 IDLE cycle between grants.
REQ-030 Abort: req=0100 with preset2=0x0000; drop req[2] after 5 RUN edges.
  -> gnt=0000 and count=0x0005 held.
  -> no done pulse.
  -> next grant with req=0110 goes to index 1 (wraps past 2, 3, 0 order: 3 and 0 idle, then 1).
REQ-031 Reset mid-RUN: rst=0 for one edge during RUN.
  -> gnt=0, count=0, busy=0, done never pulses.
  -> after reset, req=1010 grants index 1.
REQ-032 Preset latched: change preset0 from 0xFFFE to 0x0000 one cycle after the grant.
  -> done still pulses 2 edges after the grant.
